// File: rtl/fd_instr_queue.sv
// Fetch-to-decode instruction queue: small circular FIFO of {instr, pc} pairs.
// Optional perf counters (stall_cnt, flush_cnt) when FDQ_PERF_CNT_EN is defined.
module fd_instr_queue #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h3000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [31:0]              in_instr,
   input  logic [31:0]              in_pc,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_pc8,
   output logic                     out_adel,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
`ifdef FDQ_PERF_CNT_EN
   ,
   output logic [31:0]              stall_cnt,
   output logic [31:0]              flush_cnt
`endif
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CW     = ADDR_W + 1;

   logic [31:0]       instr_mem [DEPTH];
   logic [31:0]       pc_mem    [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;

   // Handshake and head presentation; empty queue shows a nop bubble at RESET_PC
   always_comb begin
      in_ready  = (count != CW'(DEPTH));
      out_valid = (count != '0);
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready & ~flush;
      out_instr = 32'h0;
      out_pc    = RESET_PC;
      out_adel  = 1'b0;
      if (out_valid) begin
         out_instr = instr_mem[rd_ptr];
         out_pc    = pc_mem[rd_ptr];
         out_adel  = |pc_mem[rd_ptr][1:0];
      end
      out_pc8 = out_pc + 32'd8;
   end

   // Pointers, occupancy and storage; flush drops everything incl. a same-cycle push
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_mem[i] <= 32'h0;
            pc_mem[i]    <= 32'h0;
         end
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
            wr_ptr            <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

`ifdef FDQ_PERF_CNT_EN
   // Count fetch stalls and flushes that actually discard entries
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else begin
         if (in_valid && !in_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush && (count != '0)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fd_instr_queue.sv
// Directed self-checking bench for fd_instr_queue (DEPTH=2).
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_fd_instr_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc8;
   logic        out_adel;
   logic        flush;
   logic [1:0]  count;
`ifdef FDQ_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fd_instr_queue #(
      .DEPTH    (2),
      .RESET_PC (32'h3000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_pc8   (out_pc8),
      .out_adel  (out_adel),
      .flush     (flush),
      .count     (count)
`ifdef FDQ_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic v, input logic [31:0] pc,
                      input logic [31:0] ins);
      in_valid = v;
      in_pc    = pc;
      in_instr = ins;
   endtask

   // Directed sequence of the scenarios
   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      put(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      reset = 1'b1;

      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc", out_pc, 32'h3000);
      chk("rst_out_pc8", out_pc8, 32'h3008);
      chk("rst_out_adel", 32'(out_adel), 32'd0);
      chk("rst_count", 32'(count), 32'd0);

      // fill until full; third word refused
      put(1'b1, 32'h3000, 32'hA000_0000);
      tick();
      chk("t1_count1", 32'(count), 32'd1);
      chk("t1_valid1", 32'(out_valid), 32'd1);
      chk("t1_ready1", 32'(in_ready), 32'd1);
      put(1'b1, 32'h3004, 32'hA000_0001);
      tick();
      chk("t1_count2", 32'(count), 32'd2);
      chk("t1_ready_full", 32'(in_ready), 32'd0);
      put(1'b1, 32'h3008, 32'hA000_0002);
      tick();
      chk("t1_count_hold", 32'(count), 32'd2);
      chk("t1_head_pc", out_pc, 32'h3000);
      chk("t1_head_pc8", out_pc8, 32'h3008);
      chk("t1_head_instr", out_instr, 32'hA000_0000);

      // drain in order; 3008 pushed once a slot frees
      out_ready = 1'b1;
      tick();
      chk("t2_pc_3004", out_pc, 32'h3004);
      chk("t2_count_a", 32'(count), 32'd1);
      tick();
      chk("t2_pc_3008", out_pc, 32'h3008);
      chk("t2_instr_3008", out_instr, 32'hA000_0002);
      chk("t2_count_b", 32'(count), 32'd1);
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("t2_count_0", 32'(count), 32'd0);
      chk("t2_valid_0", 32'(out_valid), 32'd0);

      // full queue flushed with simultaneous push and pop
      out_ready = 1'b0;
      put(1'b1, 32'h3000, 32'hB000_0000);
      tick();
      put(1'b1, 32'h3004, 32'hB000_0001);
      tick();
      chk("t3_full", 32'(count), 32'd2);
      put(1'b1, 32'h3008, 32'hB000_0002);
      out_ready = 1'b1;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      put(1'b0, 32'h0, 32'h0);
      chk("t3_count", 32'(count), 32'd0);
      chk("t3_valid", 32'(out_valid), 32'd0);
      chk("t3_instr", out_instr, 32'h0);
      chk("t3_pc", out_pc, 32'h3000);
      tick();
      chk("t3_no_ghost", 32'(count), 32'd0);

      // streaming push/pop of 8 words
      put(1'b1, 32'h4000, 32'h1000_0000);
      tick();
      out_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         put(1'b1, 32'h4000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
         tick();
         chk("t4_pc", out_pc, 32'h4000 + 32'(4 * i));
         chk("t4_instr", out_instr, 32'h1000_0000 + 32'(i));
         chk("t4_count", 32'(count), 32'd1);
      end
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("t4_drained", 32'(count), 32'd0);

      // misaligned PC and pc8 wrap
      out_ready = 1'b0;
      put(1'b1, 32'h0000_3002, 32'hC000_0000);
      tick();
      chk("t5_adel", 32'(out_adel), 32'd1);
      chk("t5_pc8_a", out_pc8, 32'h0000_300A);
      put(1'b1, 32'hFFFF_FFFC, 32'hC000_0001);
      tick();
      put(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t5_pc_wrap", out_pc, 32'hFFFF_FFFC);
      chk("t5_pc8_wrap", out_pc8, 32'h0000_0004);
      chk("t5_adel_0", 32'(out_adel), 32'd0);

      // reset wins over flush and push
      put(1'b1, 32'h5000, 32'hD000_0000);
      tick();
      chk("t6_full", 32'(count), 32'd2);
      reset = 1'b0;
      flush = 1'b1;
      put(1'b1, 32'h5004, 32'hD000_0001);
      tick();
      reset = 1'b1;
      flush = 1'b0;
      put(1'b0, 32'h0, 32'h0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_ready", 32'(in_ready), 32'd1);
      chk("t6_pc", out_pc, 32'h3000);
`ifdef FDQ_PERF_CNT_EN
      chk("t6_stall_cnt", stall_cnt, 32'd0);
      chk("t6_flush_cnt", flush_cnt, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
